// File: rtl/motion_ctrl_pkg.sv
// Shared types and default widths for the two-axis move sequencer.
package motion_ctrl_pkg;
  localparam int NUM_BITS_DEFAULT   = 16;
  localparam int WIDTH_BITS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIGGER   = 2'd1,
    WAIT_DONE = 2'd2,
    DONE      = 2'd3
  } MotionCtrl_state;
endpackage

// File: rtl/motion_ctrl_signed_to_dir_mag.sv
// Splits a signed delta into a direction bit (1 = positive) and an unsigned magnitude.
module signed_to_dir_mag
  import motion_ctrl_pkg::*;
#(
  parameter int NUM_BITS = NUM_BITS_DEFAULT
) (
  input  logic signed [NUM_BITS-1:0] delta,
  output logic                       dir,
  output logic        [NUM_BITS-1:0] mag
);
  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

  logic [NUM_BITS-1:0] delta_u;

  assign delta_u = delta;
  assign dir     = ~delta[NUM_BITS-1];
  // The most negative value negates to itself, which is the correct unsigned magnitude.
  assign mag     = delta[NUM_BITS-1] ? (~delta_u + ONE) : delta_u;
endmodule

// File: rtl/motion_ctrl.sv
// Two-axis move sequencer: latches a relative move, triggers the active steppers,
// waits for them to finish and pulses done.
module motion_ctrl
  import motion_ctrl_pkg::*;
#(
  parameter int NUM_BITS   = NUM_BITS_DEFAULT,
  parameter int WIDTH_BITS = WIDTH_BITS_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clk_en,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic signed [NUM_BITS-1:0]   cmd_dx,
  input  logic signed [NUM_BITS-1:0]   cmd_dy,
  input  logic        [WIDTH_BITS-1:0] cmd_pulse_width,
  output logic                         x_trigger,
  output logic                         y_trigger,
  output logic                         x_dir,
  output logic                         y_dir,
  output logic        [NUM_BITS-1:0]   x_pulse_num,
  output logic        [NUM_BITS-1:0]   y_pulse_num,
  output logic        [WIDTH_BITS-1:0] x_pulse_width,
  output logic        [WIDTH_BITS-1:0] y_pulse_width,
  input  logic                         x_working,
  input  logic                         y_working,
  output logic                         busy,
  output logic                         done
);
  MotionCtrl_state state_reg, state_next;

  logic                  accept;
  logic                  dx_dir, dy_dir;
  logic [NUM_BITS-1:0]   dx_mag, dy_mag;
  logic                  dx_active, dy_active;
  logic                  active_x_reg, active_y_reg;
  logic                  x_dir_reg, y_dir_reg;
  logic [NUM_BITS-1:0]   x_num_reg, y_num_reg;
  logic [WIDTH_BITS-1:0] width_reg;

  signed_to_dir_mag #(.NUM_BITS(NUM_BITS)) u_x_conv (
    .delta (cmd_dx),
    .dir   (dx_dir),
    .mag   (dx_mag)
  );

  signed_to_dir_mag #(.NUM_BITS(NUM_BITS)) u_y_conv (
    .delta (cmd_dy),
    .dir   (dy_dir),
    .mag   (dy_mag)
  );

  // A zero width would never finish a pulse, so it counts as no motion.
  assign dx_active = (cmd_dx != '0) && (cmd_pulse_width != '0);
  assign dy_active = (cmd_dy != '0) && (cmd_pulse_width != '0);

  // reset_n term keeps cmd_ready at 0 while the block is held in reset.
  assign cmd_ready = (state_reg == IDLE) && clk_en && reset_n;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE) && clk_en;
  assign x_trigger = (state_reg == TRIGGER) && active_x_reg;
  assign y_trigger = (state_reg == TRIGGER) && active_y_reg;

  assign x_dir         = x_dir_reg;
  assign y_dir         = y_dir_reg;
  assign x_pulse_num   = x_num_reg;
  assign y_pulse_num   = y_num_reg;
  assign x_pulse_width = width_reg;
  assign y_pulse_width = width_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else if (clk_en) begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = (dx_active || dy_active) ? TRIGGER : DONE;
      end
      TRIGGER:   state_next = WAIT_DONE;
      WAIT_DONE: begin
        if (!(active_x_reg && x_working) && !(active_y_reg && y_working)) state_next = DONE;
      end
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_x_reg <= 1'b0;
      active_y_reg <= 1'b0;
      x_dir_reg    <= 1'b0;
      y_dir_reg    <= 1'b0;
      x_num_reg    <= '0;
      y_num_reg    <= '0;
      width_reg    <= '0;
    end else if (accept) begin
      active_x_reg <= dx_active;
      active_y_reg <= dy_active;
      x_dir_reg    <= dx_dir;
      y_dir_reg    <= dy_dir;
      x_num_reg    <= dx_mag;
      y_num_reg    <= dy_mag;
      width_reg    <= cmd_pulse_width;
    end
  end
endmodule

// File: tb/tb_motion_ctrl.sv
// Self-checking bench for motion_ctrl: table of moves with a scoreboard queue plus
// hand-written sequences for clk_en stalls and mid-move reset.
module tb_motion_ctrl;
  localparam int NB = 16;
  localparam int WB = 16;

  typedef struct {
    logic signed [NB-1:0] dx;
    logic signed [NB-1:0] dy;
    logic [WB-1:0]        w;
    int                   x_len;
    int                   y_len;
    bit                   x_force;
    bit                   x_trig;
    bit                   y_trig;
    bit                   x_dir;
    logic [NB-1:0]        x_num;
    bit                   y_dir;
    logic [NB-1:0]        y_num;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 reset_n = 1'b0;
  logic                 clk_en = 1'b0;
  logic                 cmd_valid = 1'b0;
  logic                 cmd_ready;
  logic signed [NB-1:0] cmd_dx = '0;
  logic signed [NB-1:0] cmd_dy = '0;
  logic [WB-1:0]        cmd_pulse_width = '0;
  logic                 x_trigger, y_trigger, x_dir, y_dir;
  logic [NB-1:0]        x_pulse_num, y_pulse_num;
  logic [WB-1:0]        x_pulse_width, y_pulse_width;
  logic                 x_working, y_working;
  logic                 busy, done;

  int   errors = 0;
  int   checks = 0;
  vec_t exp_q[$];
  vec_t tbl[6];
  vec_t post_rst;

  // Behavioural stepper models: busy for *_len enabled cycles after sampling a trigger.
  int x_len = 1, y_len = 1;
  int x_cnt = 0, y_cnt = 0;
  bit x_force = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_cnt <= 0;
      y_cnt <= 0;
    end else if (clk_en) begin
      if (x_trigger) x_cnt <= x_len; else if (x_cnt != 0) x_cnt <= x_cnt - 1;
      if (y_trigger) y_cnt <= y_len; else if (y_cnt != 0) y_cnt <= y_cnt - 1;
    end
  end

  assign x_working = (x_cnt != 0) || x_force;
  assign y_working = (y_cnt != 0);

  motion_ctrl #(.NUM_BITS(NB), .WIDTH_BITS(WB)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .clk_en          (clk_en),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_dx          (cmd_dx),
    .cmd_dy          (cmd_dy),
    .cmd_pulse_width (cmd_pulse_width),
    .x_trigger       (x_trigger),
    .y_trigger       (y_trigger),
    .x_dir           (x_dir),
    .y_dir           (y_dir),
    .x_pulse_num     (x_pulse_num),
    .y_pulse_num     (y_pulse_num),
    .x_pulse_width   (x_pulse_width),
    .y_pulse_width   (y_pulse_width),
    .x_working       (x_working),
    .y_working       (y_working),
    .busy            (busy),
    .done            (done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input vec_t v);
    int m = 0;
    if (v.x_trig && v.x_len > m) m = v.x_len;
    if (v.y_trig && v.y_len > m) m = v.y_len;
    return (v.x_trig || v.y_trig) ? m + 3 : 1;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int   cyc;
    bit   ready_seen;
    x_len = v.x_len;
    y_len = v.y_len;
    x_force = v.x_force;
    cmd_dx = v.dx;
    cmd_dy = v.dy;
    cmd_pulse_width = v.w;
    cmd_valid = 1'b1;
    cyc = 0;
    while (!cmd_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("accept_wait", cmd_ready, 1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_q.push_back(v);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("x_trigger", x_trigger, v.x_trig);
    chk("y_trigger", y_trigger, v.y_trig);
    chk("busy_after_accept", busy, 1);
    cyc = 1;
    ready_seen = 1'b0;
    while (!done && cyc < 300) begin
      ready_seen |= cmd_ready;
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", cyc, exp_latency(v));
    chk("ready_during_move", ready_seen, 0);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("x_dir", x_dir, e.x_dir);
      chk("x_pulse_num", x_pulse_num, e.x_num);
      chk("y_dir", y_dir, e.y_dir);
      chk("y_pulse_num", y_pulse_num, e.y_num);
      chk("x_pulse_width", x_pulse_width, e.w);
      chk("y_pulse_width", y_pulse_width, e.w);
    end
    @(negedge clk);
    chk("done_single", done, 0);
    chk("ready_after_done", cmd_ready, 1);
    x_force = 1'b0;
    $display("txn %0d: dx=%0d dy=%0d w=%0d done after %0d cycles", idx, v.dx, v.dy, v.w, cyc);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int done_cnt;
    int trig_cnt;
    //           dx         dy         w         xl yl xf xt yt xd xnum       yd ynum
    tbl[0] = '{16'sd5,    16'shFFFD, 16'd4,    3, 5, 0, 1, 1, 1, 16'd5,    0, 16'd3};
    tbl[1] = '{16'sd0,    16'sd7,    16'd2,    1, 2, 1, 0, 1, 1, 16'd0,    1, 16'd7};
    tbl[2] = '{16'sd0,    16'sd0,    16'd9,    1, 1, 0, 0, 0, 1, 16'd0,    1, 16'd0};
    tbl[3] = '{16'sd4,    16'sd0,    16'd0,    1, 1, 0, 0, 0, 1, 16'd4,    1, 16'd0};
    tbl[4] = '{16'sh8000, 16'sd1,    16'd1,    2, 1, 0, 1, 1, 0, 16'h8000, 1, 16'd1};
    tbl[5] = '{16'sh7FFF, 16'shFFFF, 16'hFFFF, 1, 1, 0, 1, 1, 1, 16'h7FFF, 0, 16'd1};
    post_rst = '{16'sd2,  16'sd0,    16'd3,    2, 1, 0, 1, 0, 1, 16'd2,    1, 16'd0};

    reset_n = 1'b0;
    clk_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_triggers", {x_trigger, y_trigger}, 0);
    chk("rst_dirs", {x_dir, y_dir}, 0);
    chk("rst_pulse_nums", {x_pulse_num, y_pulse_num}, 0);
    chk("rst_widths", {x_pulse_width, y_pulse_width}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);

    foreach (tbl[i]) run_vec(tbl[i], i);

    // clk_en stall while in TRIGGER; spurious cmd_valid pulses must be ignored.
    x_len = 2;
    cmd_dx = 16'sd3;
    cmd_dy = 16'sd0;
    cmd_pulse_width = 16'd1;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_dx = 16'sd9;
    clk_en = 1'b0;
    chk("stall_trig_0", x_trigger, 1);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      cmd_valid = (k == 2);
      chk($sformatf("stall_trig_%0d", k), x_trigger, 1);
    end
    cmd_valid = 1'b0;
    clk_en = 1'b1;
    @(negedge clk);
    chk("stall_trig_drop", x_trigger, 0);
    chk("stall_busy", busy, 1);
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    done_cnt = 0;
    trig_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      done_cnt += int'(done);
      trig_cnt += int'(x_trigger || y_trigger);
      @(negedge clk);
    end
    chk("stall_done_count", done_cnt, 1);
    chk("stall_no_retrigger", trig_cnt, 0);
    chk("stall_idle", busy, 0);
    chk("stall_num_held", x_pulse_num, 3);
    $display("txn stall: dx=3 clk_en low 5 clks, dones=%0d", done_cnt);

    // Asynchronous reset in the middle of WAIT_DONE.
    x_len = 10;
    cmd_dx = 16'sd6;
    cmd_pulse_width = 16'd3;
    cmd_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_before_reset", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", cmd_ready, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_trig", {x_trigger, y_trigger}, 0);
    chk("mid_rst_num", x_pulse_num, 0);
    chk("mid_rst_dir", x_dir, 0);
    chk("mid_rst_width", x_pulse_width, 0);
    $display("txn reset: asserted mid-move");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_vec(post_rst, 99);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
